// File: rtl/parity_frame_gen.sv
// parity_frame_gen: streaming even/odd parity over multi-beat frames with check mode
// and a one-entry result buffer that supports back-to-back results.
module parity_frame_gen #(
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   input  logic [DATA_W-1:0]            i_in_data,
   input  logic                         i_in_last,
   input  logic                         i_odd_mode,
   input  logic                         i_chk_en,
   input  logic                         i_chk_bit,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic                         o_out_parity,
   output logic [$clog2(MAX_LEN+1)-1:0] o_out_len,
   output logic                         o_out_trunc,
   output logic                         o_out_err
);
   localparam int LEN_W = $clog2(MAX_LEN+1);
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t r_state, w_next;
   logic r_acc, r_odd, r_out_valid, r_out_parity, r_out_trunc, r_out_err;
   logic [LEN_W-1:0] r_count, r_out_len, w_len;
   logic w_beat, w_first, w_close, w_acc, w_odd, w_parity;
   // The first beat of a frame starts from a clean accumulator and samples odd_mode live.
   assign w_beat   = i_in_valid & o_in_ready;
   assign w_first  = r_state == IDLE;
   assign w_len    = w_first ? LEN_W'(1) : LEN_W'(r_count + 1'b1);
   assign w_close  = w_beat & (i_in_last | (w_len == LEN_W'(MAX_LEN)));
   assign w_odd    = w_first ? i_odd_mode : r_odd;
   assign w_acc    = (w_first ? 1'b0 : r_acc) ^ (^i_in_data);
   assign w_parity = w_acc ^ w_odd;
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = w_beat ? (w_close ? IDLE : ACCUM) : r_state;
   end
   always_comb begin
      o_in_ready   = !r_out_valid | i_out_ready;
      o_out_valid  = r_out_valid;
      o_out_parity = r_out_parity;
      o_out_len    = r_out_len;
      o_out_trunc  = r_out_trunc;
      o_out_err    = r_out_err;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= 1'b0;
         r_odd   <= 1'b0;
         r_count <= '0;
      end else if (w_beat) begin
         r_acc   <= w_acc;
         r_odd   <= w_odd;
         r_count <= w_close ? '0 : w_len;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_parity <= 1'b0;
         r_out_len    <= '0;
         r_out_trunc  <= 1'b0;
         r_out_err    <= 1'b0;
      end else if (w_close) begin
         r_out_valid  <= 1'b1;
         r_out_parity <= w_parity;
         r_out_len    <= w_len;
         r_out_trunc  <= !i_in_last;
         r_out_err    <= i_chk_en & (i_chk_bit ^ w_parity);
      end else if (i_out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_parity_frame_gen.sv
// tb_parity_frame_gen: directed checks of frame parity, truncation, backpressure,
// check mode and reset for DATA_W=8, MAX_LEN=4.
module tb_parity_frame_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, in_ready, in_last = 1'b0, odd_mode = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       chk_en = 1'b0, chk_bit = 1'b0;
   logic       out_valid, out_ready = 1'b1, out_parity, out_trunc, out_err;
   logic [2:0] out_len;
   int tests = 0, fails = 0;

   parity_frame_gen #(.DATA_W(8), .MAX_LEN(4)) dut (
      .clk(clk), .rst(rst),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .i_in_last(in_last), .i_odd_mode(odd_mode), .i_chk_en(chk_en), .i_chk_bit(chk_bit),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_parity(out_parity),
      .o_out_len(out_len), .o_out_trunc(out_trunc), .o_out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic p, input logic [2:0] l,
                          input logic t, input logic e);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".parity"}, 32'(out_parity), 32'(p));
      chk({tag, ".len"}, 32'(out_len), 32'(l));
      chk({tag, ".trunc"}, 32'(out_trunc), 32'(t));
      chk({tag, ".err"}, 32'(out_err), 32'(e));
   endtask

   task automatic beat(input logic [7:0] d, input logic last, input logic odd);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      odd_mode = odd;
      tick();
      in_valid = 1'b0;
      in_data  = 8'hXX;
   endtask

   initial begin
      tick();
      tick();
      chk_out("reset", 0, 0, 0, 0, 0);
      chk("reset.in_ready", 32'(in_ready), 1);
      rst = 1'b0;
      // single-beat frames, even then odd
      beat(8'hA5, 1, 0);
      chk_out("t1_even", 1, 0, 1, 0, 0);
      beat(8'hA5, 1, 1);
      chk_out("t1_odd", 1, 1, 1, 0, 0);
      tick();
      chk("t1_drain", 32'(out_valid), 0);
      // three-beat frame, odd_mode change mid-frame ignored
      beat(8'h01, 0, 0);
      chk("t2_midframe", 32'(out_valid), 0);
      beat(8'h03, 0, 0);
      beat(8'h07, 1, 0);
      chk_out("t2_len3", 1, 0, 3, 0, 0);
      beat(8'h01, 0, 0);
      beat(8'h03, 0, 1);
      beat(8'h07, 1, 1);
      chk_out("t2_oddchg", 1, 0, 3, 0, 0);
      // force-close at MAX_LEN, then new frame
      beat(8'hFF, 0, 0);
      beat(8'hFF, 0, 0);
      beat(8'hFF, 0, 0);
      beat(8'hFF, 0, 0);
      chk_out("t3_trunc", 1, 0, 4, 1, 0);
      beat(8'h01, 0, 0);
      chk("t3_after", 32'(out_valid), 0);
      beat(8'h00, 1, 0);
      chk_out("t3_next", 1, 1, 2, 0, 0);
      beat(8'h00, 0, 0);
      beat(8'h00, 0, 0);
      beat(8'h00, 0, 0);
      beat(8'h01, 1, 0);
      chk_out("t3_last_at_max", 1, 1, 4, 0, 0);
      // backpressure hold then simultaneous handshakes
      beat(8'h01, 1, 0);
      chk_out("t4_load", 1, 1, 1, 0, 0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h03;
      in_last   = 1'b1;
      odd_mode  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_in_ready_low", 32'(in_ready), 0);
         tick();
         chk_out("t4_hold", 1, 1, 1, 0, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("t4_in_ready_high", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk_out("t4_b2b", 1, 0, 1, 0, 0);
      tick();
      chk("t4_drain", 32'(out_valid), 0);
      // check mode
      chk_en  = 1'b1;
      chk_bit = 1'b0;
      beat(8'h80, 1, 0);
      chk_out("t5_err", 1, 1, 1, 0, 1);
      chk_bit = 1'b1;
      beat(8'h80, 1, 0);
      chk_out("t5_ok", 1, 1, 1, 0, 0);
      chk_en  = 1'b0;
      chk_bit = 1'b0;
      beat(8'h80, 1, 0);
      chk_out("t5_off", 1, 1, 1, 0, 0);
      // reset mid-frame discards partial frame
      beat(8'hFF, 0, 0);
      beat(8'h01, 0, 0);
      rst = 1'b1;
      tick();
      chk_out("t6_reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      beat(8'h01, 1, 0);
      chk_out("t6_fresh", 1, 1, 1, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
